// File: rtl/rsa_modexp_seq.sv
// ============================================================================
// Module  : rsa_modexp_seq
// Brief   : Sequential right-to-left square-and-multiply modular exponentiation
//           with bit-serial restoring reduction. Optional macro:
//           RSA_MODEXP_EARLY_EXIT_EN (stop once the remaining exponent is zero).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rsa_modexp_seq #(
    parameter int WIDTH = 8,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int c_PW = 2 * WIDTH;
    localparam int c_KW = $clog2(c_PW);
    localparam int c_IW = $clog2(EXP_W + 1);
    localparam logic [c_KW-1:0] c_K_LAST  = c_KW'(c_PW - 1);
    localparam logic [c_IW-1:0] c_IT_LAST = c_IW'(EXP_W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REDB = 3'd1,
        S_MULR = 3'd2,
        S_SQR  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d, mod_q, mod_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] acc_q, acc_d, b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [c_KW-1:0]  k_q, k_d;
    logic [c_IW-1:0]  it_q, it_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] w_opa, w_opb, w_red;
    logic [c_PW-1:0]  w_prod;
    logic [WIDTH:0]   w_shift;
    logic             w_op_last;

    // Shared multiply operand selection; the remainder always stays below the
    // modulus, so only the shifted value needs the extra bit.
    always_comb begin
        w_opa = b_q;
        w_opb = b_q;
        case (state_q)
            S_REDB: begin w_opa = base_q; w_opb = WIDTH'(1); end
            S_MULR: begin w_opa = acc_q;  w_opb = b_q;       end
            default: ;
        endcase
    end

    assign w_prod    = {{WIDTH{1'b0}}, w_opa} * {{WIDTH{1'b0}}, w_opb};
    assign w_shift   = {r_q, w_prod[c_K_LAST - k_q]};
    assign w_red     = (w_shift >= {1'b0, mod_q}) ? WIDTH'(w_shift - {1'b0, mod_q})
                                                  : w_shift[WIDTH-1:0];
    assign w_op_last = (k_q == c_K_LAST);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        mod_d    = mod_q;
        exp_d    = exp_q;
        acc_d    = acc_q;
        b_d      = b_q;
        r_d      = r_q;
        k_d      = k_q;
        it_d     = it_q;
        result_d = result_q;
        err_d    = err_q;
        if ((state_q == S_REDB) || (state_q == S_MULR) || (state_q == S_SQR)) begin
            r_d = w_red;
            k_d = k_q + c_KW'(1);
            if (w_op_last) begin
                r_d = '0;
                k_d = '0;
            end
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = base;
                    exp_d  = exponent;
                    mod_d  = modulus;
                    err_d  = 1'b0;
                    r_d    = '0;
                    k_d    = '0;
                    it_d   = '0;
                    b_d    = '0;
                    if (modulus == '0) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = S_FIN;
                    end else begin
                        acc_d   = (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                        state_d = S_REDB;
                    end
                end
            end
            S_REDB: begin
                if (w_op_last) begin
                    b_d     = w_red;
                    state_d = S_MULR;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
                    if (exp_q == '0) begin
                        result_d = acc_q;
                        state_d  = S_FIN;
                    end
`endif
                end
            end
            S_MULR: begin
                if (w_op_last) begin
                    if (exp_q[0]) acc_d = w_red;
                    state_d = S_SQR;
                end
            end
            S_SQR: begin
                if (w_op_last) begin
                    b_d     = w_red;
                    exp_d   = exp_q >> 1;
                    it_d    = it_q + c_IW'(1);
                    state_d = S_MULR;
                    if (it_q == c_IT_LAST) state_d = S_FIN;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
                    if ((exp_q >> 1) == '0) state_d = S_FIN;
`endif
                    if (state_d == S_FIN) result_d = acc_q;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            mod_q    <= '0;
            exp_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            r_q      <= '0;
            k_q      <= '0;
            it_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            mod_q    <= mod_d;
            exp_q    <= exp_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            r_q      <= r_d;
            k_q      <= k_d;
            it_q     <= it_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q == S_REDB) || (state_q == S_MULR) || (state_q == S_SQR);
    assign done   = (state_q == S_FIN);
    assign result = result_q;
    assign err    = err_q;

endmodule

`default_nettype wire

// File: doc/rsa_modexp_seq.md
Name: rsa_modexp_seq

Overview:
- Sequential modular-exponentiation engine. Computes result = base^exponent mod modulus using right-to-left square-and-multiply.
- Each modular multiply is reduced by a restoring shift-subtract loop, one product bit per cycle. No divider and no % operator.
- Sits downstream of uart_rx, which supplies byte operands, and upstream of uart_tx, which consumes result on done.
- Replaces the single-cycle function-based exponentiation with a bounded, constant-latency datapath.

Parameters:
- WIDTH, 8, bit width of base, modulus and result.
- EXP_W, 8, bit width of exponent; also the number of exponent iterations.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- base  input  WIDTH  message or ciphertext operand
- exponent  input  EXP_W  e or d
- modulus  input  WIDTH  n
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  base^exponent mod modulus; held until the next done
- err  output  1  set with done when modulus==0; cleared on the next accepted start

Behaviour:
- Reset: async assert returns the FSM to IDLE. busy=0, done=0, result=0, err=0; all internal registers cleared.
- Reset mid-operation: computation is abandoned and no done is produced.
- States: IDLE -> REDB -> {MULR -> SQR} x EXP_W -> FIN -> IDLE.
- IDLE:
  - On start=1, latch base, exponent and modulus; inputs are ignored afterwards. Clear err.
  - If modulus==0: go to FIN with err=1 and result=0 (done one cycle after acceptance).
  - Otherwise go to REDB. Set acc = (modulus==1) ? 0 : 1.
- start while busy or in FIN: ignored, no queueing.
- Modular-multiply micro-op, shared by REDB, MULR and SQR:
  - Product P = A*B, 2*WIDTH bits, formed combinationally from registered operands.
  - Remainder r is WIDTH+1 bits and is cleared on state entry.
  - Over 2*WIDTH cycles, k = 0..2*WIDTH-1: r = (r<<1) | P[2*WIDTH-1-k]; then if r >= modulus, r = r - modulus.
  - The op's output is r[WIDTH-1:0] after the last cycle.
- REDB: A=base, B=1; output goes to b.
- MULR: A=acc, B=b. The output is written to acc only if exp_sh[0]==1. The op always runs, which keeps latency constant.
- SQR: A=b, B=b; output goes to b. Then exp_sh >>= 1 and the iteration counter increments. After EXP_W iterations go to FIN; else go to MULR.
- FIN: result <= acc (or 0 on err), done=1 for one cycle, busy=0, return to IDLE.
- Latency for a nonzero modulus: done is high in cycle 2*WIDTH*(1+2*EXP_W)+1 after the accepting edge. Defaults give 273.
- start may be reasserted in the cycle after done and is accepted.
- Ranges: exponent==0 gives result 1 (0 if modulus==1). base>=modulus is legal and reduced in REDB. All intermediate values stay < modulus.

Optional Feature:
- Macro: RSA_MODEXP_EARLY_EXIT_EN.
- Defined: after SQR, if the remaining exp_sh==0, go directly to FIN.
  - Latency becomes 2*WIDTH*(1+2*L)+1, where L = bit length of exponent (L=0 for exponent 0: REDB then FIN).
  - This mode is not constant-time.
- Undefined: fixed latency as specified above.
- Results are identical in both builds.

Test Plan:
- base=2, exponent=7, modulus=143 -> result=128, err=0, done exactly 273 cycles after start, busy high throughout.
- base=128, exponent=103, modulus=143 -> result=2 (round-trip decrypt); then base=9, exponent=7 -> result=48.
- base=200, exponent=1, modulus=143 -> 57; base=5, exponent=0, modulus=143 -> 1; base=5, exponent=0, modulus=1 -> 0.
- modulus=0, any base/exponent -> done one cycle after acceptance, err=1, result=0. A following valid start clears err.
- Pulse start with new operands at cycle 10 of a running op -> ignored; the original result is delivered. Back-to-back start on the cycle after done -> accepted.
- Assert reset at cycle 100 of an op -> busy=0, result=0 immediately, no done pulse. Restart completes normally.
- With RSA_MODEXP_EARLY_EXIT_EN: base=2, exponent=7, modulus=143 -> result 128, done after 2*8*(1+6)+1=113 cycles.
